// File: rtl/pic_host_sequencer.sv
// Host-side sequencer for an 8259-style PIC: issues the ICW init sequence,
// non-specific EOI writes and the two-pulse INTA acknowledge cycle.
module pic_host_sequencer #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_init,
  input  logic [7:0] cfg_icw1,
  input  logic [7:0] cfg_icw2,
  input  logic [7:0] cfg_icw3,
  input  logic [7:0] cfg_icw4,
  input  logic       eoi_req,
  input  logic       int_req,
  input  logic [7:0] data_in,
  output logic       cs_n,
  output logic       wr_n,
  output logic       inta_n,
  output logic       a0,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       busy,
  output logic       init_done
);

  typedef enum logic [3:0] {
    IDLE, WR_SETUP, WR_PULSE, WR_HOLD, NEXT_WORD, ACK1, ACK_GAP, ACK2, ACK_DONE
  } state_t;

  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYCLES);
  localparam logic [3:0] GAP_LD   = 4'(GAP_CYCLES);

  state_t     state;
  logic [3:0] cnt;
  logic       last;
  logic [7:0] icw1_q, icw2_q, icw3_q, icw4_q;
  logic [1:0] word_idx;
  logic       init_wr;
  logic       eoi_pend;
  logic       has_next;
  logic [1:0] nxt_idx;
  logic [7:0] cur_data;

  assign last = (cnt == 4'd1);

  // Which ICW follows the current one; ICW3 only in cascade, ICW4 only if requested.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    has_next = 1'b0;
    nxt_idx  = word_idx;
    if (init_wr) begin
      unique case (word_idx)
        2'd0: begin has_next = 1'b1; nxt_idx = 2'd1; end
        2'd1: begin
          if (!icw1_q[1])     begin has_next = 1'b1; nxt_idx = 2'd2; end
          else if (icw1_q[0]) begin has_next = 1'b1; nxt_idx = 2'd3; end
        end
        2'd2: if (icw1_q[0]) begin has_next = 1'b1; nxt_idx = 2'd3; end
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (word_idx)
      2'd0:    cur_data = icw1_q;
      2'd1:    cur_data = icw2_q;
      2'd2:    cur_data = icw3_q;
      default: cur_data = icw4_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      cs_n         <= 1'b1;
      wr_n         <= 1'b1;
      inta_n       <= 1'b1;
      a0           <= 1'b0;
      data_out     <= 8'h00;
      data_oe      <= 1'b0;
      vector       <= 8'h00;
      vector_valid <= 1'b0;
      busy         <= 1'b0;
      init_done    <= 1'b0;
      eoi_pend     <= 1'b0;
      icw1_q       <= 8'h00;
      icw2_q       <= 8'h00;
      icw3_q       <= 8'h00;
      icw4_q       <= 8'h00;
      word_idx     <= 2'd0;
      init_wr      <= 1'b0;
    end else begin
      vector_valid <= 1'b0;
      if (state != IDLE) cnt <= cnt - 4'd1;
      if (state != IDLE && eoi_req && init_done) eoi_pend <= 1'b1;

      unique case (state)
        IDLE: begin
          if (start_init) begin
            icw1_q    <= cfg_icw1 | 8'h10;
            icw2_q    <= cfg_icw2;
            icw3_q    <= cfg_icw3;
            icw4_q    <= cfg_icw4;
            init_done <= 1'b0;
            eoi_pend  <= 1'b0;
            init_wr   <= 1'b1;
            word_idx  <= 2'd0;
            a0        <= 1'b0;
            data_out  <= cfg_icw1 | 8'h10;
            cs_n      <= 1'b0;
            data_oe   <= 1'b1;
            busy      <= 1'b1;
            cnt       <= 4'd1;
            state     <= WR_SETUP;
          end else if (init_done && (eoi_req || eoi_pend)) begin
            eoi_pend <= 1'b0;
            init_wr  <= 1'b0;
            a0       <= 1'b0;
            data_out <= 8'h20;
            cs_n     <= 1'b0;
            data_oe  <= 1'b1;
            busy     <= 1'b1;
            cnt      <= 4'd1;
            state    <= WR_SETUP;
          end else if (init_done && int_req) begin
            inta_n <= 1'b0;
            busy   <= 1'b1;
            cnt    <= PULSE_LD;
            state  <= ACK1;
          end
        end
        WR_SETUP: if (last) begin
          wr_n  <= 1'b0;
          cnt   <= PULSE_LD;
          state <= WR_PULSE;
        end
        WR_PULSE: if (last) begin
          wr_n  <= 1'b1;
          cnt   <= 4'd1;
          state <= WR_HOLD;
        end
        WR_HOLD: if (last) begin
          cs_n    <= 1'b1;
          data_oe <= 1'b0;
          if (has_next) begin
            word_idx <= nxt_idx;
            cnt      <= 4'd1;
            state    <= NEXT_WORD;
          end else begin
            if (init_wr) init_done <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        NEXT_WORD: if (last) begin
          a0       <= 1'b1;
          data_out <= cur_data;
          cs_n     <= 1'b0;
          data_oe  <= 1'b1;
          cnt      <= 4'd1;
          state    <= WR_SETUP;
        end
        ACK1: if (last) begin
          inta_n <= 1'b1;
          cnt    <= GAP_LD;
          state  <= ACK_GAP;
        end
        ACK_GAP: if (last) begin
          inta_n <= 1'b0;
          cnt    <= PULSE_LD;
          state  <= ACK2;
        end
        ACK2: if (last) begin
          vector       <= data_in;
          vector_valid <= 1'b1;
          inta_n       <= 1'b1;
          cnt          <= 4'd1;
          state        <= ACK_DONE;
        end
        ACK_DONE: if (last) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pic_host_sequencer.md
PIC_HOST_SEQUENCER -- requirements
Module: pic_host_sequencer

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 2, meaning low width in clocks of every wr_n and inta_n pulse (legal 1..15).
REQ-002 SHALL have parameter GAP_CYCLES, default 1, meaning high time in clocks between the two inta_n pulses (legal 1..15).
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-004 SHALL have the following ports (name  direction  width  meaning):
- start_init  in  1  pulse; begin ICW sequence
- cfg_icw1, cfg_icw2, cfg_icw3, cfg_icw4  in  8 each  init words
- eoi_req  in  1  pulse; request non-specific EOI
- int_req  in  1  INT from the PIC
- data_in  in  8  PIC data bus, read side
- cs_n, wr_n, inta_n  out  1 each  active-low strobes
- a0  out  1  PIC address bit
- data_out  out  8  write data
- data_oe  out  1  data_out drive enable
- vector  out  8  captured interrupt vector
- vector_valid  out  1  one-cycle pulse when vector updates
- busy  out  1  FSM not in IDLE
- init_done  out  1  init sequence complete

Function
REQ-005 SHALL implement states IDLE, WR_SETUP, WR_PULSE, WR_HOLD, NEXT_WORD, ACK1, ACK_GAP, ACK2, ACK_DONE.
REQ-006 SHALL perform a bus write as follows:
- WR_SETUP, 1 cycle: cs_n=0, a0 and data_out valid, data_oe=1, wr_n=1.
- WR_PULSE, PULSE_CYCLES cycles: wr_n=0.
- WR_HOLD, 1 cycle: wr_n=1, cs_n=0, data held.
REQ-007 SHALL, on start_init in IDLE, clear init_done and write ICW1 with a0=0 and data = cfg_icw1 with bit4 forced to 1.
REQ-008 SHALL then write ICW2 (a0=1, cfg_icw2), then ICW3 (a0=1, cfg_icw3) only if cfg_icw1[1]=0, then ICW4 (a0=1, cfg_icw4) only if cfg_icw1[0]=1.
REQ-009 SHALL sample cfg_icw1..4 into internal registers on the start_init cycle; later changes to the cfg inputs do not affect a running sequence.
REQ-010 SHALL pass through NEXT_WORD for 1 cycle between words with cs_n=1, wr_n=1, data_oe=0.
REQ-011 SHALL set init_done=1 in the cycle after the final WR_HOLD and return to IDLE.
REQ-012 SHALL, on eoi_req with init_done=1, write OCW2=0x20 with a0=0 using the REQ-006 timing.
REQ-013 SHALL perform an acknowledge when in IDLE with init_done=1 and int_req=1:
- ACK1: inta_n=0 for PULSE_CYCLES cycles.
- ACK_GAP: inta_n=1 for GAP_CYCLES cycles.
- ACK2: inta_n=0 for PULSE_CYCLES cycles; data_in is registered into vector on the last ACK2 cycle.
- ACK_DONE: 1 cycle with inta_n=1 and vector_valid=1, then IDLE.
REQ-014 SHALL apply IDLE priority: pending start_init > pending EOI > int_req.
REQ-015 SHALL latch an eoi_req arriving while busy as pending, serviced on the next return to IDLE; multiple requests collapse into one.
REQ-016 SHALL ignore start_init while busy (not latched).
REQ-017 SHALL ignore eoi_req while init_done=0 (not latched).
REQ-018 SHALL ignore a deassertion of int_req after ACK1 has started; the sequence completes regardless.
REQ-019 SHALL use a 4-bit down-counter loaded with the parameter value on state entry; the state advances when the count reaches 1.
REQ-020 SHALL keep data_oe=0 at all times when cs_n=1 and throughout ACK states; inta_n and wr_n are never low in the same cycle.

Reset
REQ-021 SHALL, on reset at any point including mid-write or mid-acknowledge, enter IDLE on the next edge with: cs_n=1, wr_n=1, inta_n=1, a0=0, data_out=0x00, data_oe=0, vector=0x00, vector_valid=0, busy=0, init_done=0, pending EOI cleared.

Verification
REQ-022 SHALL verify single mode: cfg_icw1=0x13, icw2=0x08, icw4=0x01, start_init -> exactly 3 wr_n pulses with (a0, data) = (0,0x13), (1,0x08), (1,0x01); no ICW3; init_done=1; busy high for 3*(PULSE_CYCLES+2)+2 cycles with defaults.
REQ-023 SHALL verify cascade mode without ICW4: cfg_icw1=0x10, icw2=0x20, icw3=0x04 -> writes (0,0x10), (1,0x20), (1,0x04) only.
REQ-024 SHALL verify acknowledge: after init, int_req=1 with data_in=0x0B during ACK2 -> two inta_n low pulses of 2 cycles separated by 1 high cycle; vector=0x0B; vector_valid high exactly 1 cycle.
REQ-025 SHALL verify pending EOI: eoi_req pulsed during ACK1 with int_req held -> the acknowledge completes, then exactly one write (0,0x20) occurs before any second acknowledge.
REQ-026 SHALL verify reset mid-operation: reset asserted during the ICW2 WR_PULSE -> next cycle all outputs at reset values; later start_init restarts from ICW1.
REQ-027 SHALL verify the gating rules: eoi_req and int_req before init_done -> no bus activity; start_init during an acknowledge -> ignored.
